vga_cfg_sched: RTL and testbench

Frame-synchronous configuration scheduler for the VGA driver. CPU-side register block that holds shadow copies of the driver's `ctrl`, `img_point` and `img_size` words. It commits them atomically to the driver at the next frame boundary, clamping the sprite rectangle to the visible area. It also keeps a frame counter and raises a vblank/commit interrupt.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_geom_clamp.sv | 28 ++
 rtl/vga_cfg_sched.sv | 191 +++++++++++++++++++
 tb/tb_vga_cfg_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA driver configuration path.
//   - Default visible area used for clamping the sprite rectangle.
//   - Register word offsets of the configuration scheduler.
//   - Scheduler state encoding.
//   - Packed position and size layouts as seen by the driver.
//   - merge_bytes(): byte-enable merge of a bus write into a 32-bit register.
package vga_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  localparam logic [2:0] REG_SH_CTRL   = 3'd0;
  localparam logic [2:0] REG_SH_POINT  = 3'd1;
  localparam logic [2:0] REG_SH_SIZE   = 3'd2;
  localparam logic [2:0] REG_COMMIT    = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_IRQ_EN    = 3'd5;
  localparam logic [2:0] REG_FRAME_CNT = 3'd6;
  localparam logic [2:0] REG_ACT_SIZE  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } cfg_state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } vga_point_t;

  typedef struct packed {
    logic [15:0] height;
    logic [15:0] width;
  } vga_size_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_geom_clamp.sv
// Combinational clamp of one sprite axis against the visible area.
//   pos         : start coordinate on this axis
//   len         : requested length on this axis
//   limit       : visible extent on this axis
//   len_clamped : length trimmed so that pos + length never passes limit;
//                 zero when the start lies entirely off-screen
module vga_geom_clamp (
  input  logic [15:0] pos,
  input  logic [15:0] len,
  input  logic [15:0] limit,
  output logic [15:0] len_clamped
);

  // 17 bits so a large position plus a large length cannot wrap past limit.
  logic [16:0] end_sum;

  assign end_sum = {1'b0, pos} + {1'b0, len};

  always_comb begin
    len_clamped = len;
    if (pos >= limit) begin
      len_clamped = '0;
    end else if (end_sum > {1'b0, limit}) begin
      len_clamped = limit - pos;
    end
  end

endmodule

// File: rtl/vga_cfg_sched.sv
// Frame-synchronous configuration scheduler for the VGA driver.
// Holds CPU-written shadow copies of ctrl / img_point / img_size and copies
// them to the driver all at once on the next frame boundary (or immediately
// when the driver is stopped), clamping the sprite size to the visible area.
// Also counts frames and raises a vblank / commit-done interrupt.
//   clk, rst        : clock, synchronous active-low reset
//   req/we/addr/    : single-cycle register bus, no backpressure
//   wdata/wstrb
//   ack, rdata      : ack is req delayed one cycle; rdata valid with ack only
//   frame_sync      : driver vs; rising edge is the frame boundary
//   ctrl, img_point,: active configuration driven to the VGA driver
//   img_size
//   irq             : level interrupt, OR of enabled status bits
module vga_cfg_sched
  import vga_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic        frame_sync,
  output logic [31:0] ctrl,
  output logic [31:0] img_point,
  output logic [31:0] img_size,
  output logic        irq
);

  localparam logic [15:0] H_LIM = H_DISP[15:0];
  localparam logic [15:0] V_LIM = V_DISP[15:0];

  cfg_state_e  state_reg, state_next;
  logic [31:0] sh_ctrl_reg, sh_point_reg, sh_size_reg;
  logic [31:0] ctrl_reg, point_reg, size_reg;
  logic [1:0]  status_reg, status_next;
  logic [1:0]  irq_en_reg;
  logic [31:0] frame_cnt_reg;
  logic        frame_sync_d_reg;
  logic        ack_reg;
  logic [31:0] rdata_reg;
  logic        irq_reg;

  logic        wr_en, rd_en, sync_edge, commit_wr;
  logic [1:0]  status_set, status_w1c;
  logic [31:0] rd_mux;

  assign wr_en     = req & we;
  assign rd_en     = req & ~we;
  assign sync_edge = frame_sync & ~frame_sync_d_reg;
  assign commit_wr = wr_en && (addr == REG_COMMIT) && wdata[0];

  // ---------------------------------------------------------------- clamp
  vga_point_t sh_pt;
  vga_size_t  sh_sz, clamped_sz;
  logic [15:0] ax_pos [2];
  logic [15:0] ax_len [2];
  logic [15:0] ax_lim [2];
  logic [15:0] ax_out [2];

  assign sh_pt = vga_point_t'(sh_point_reg);
  assign sh_sz = vga_size_t'(sh_size_reg);

  // Axis 0 is horizontal (x / width), axis 1 vertical (y / height).
  assign ax_pos[0] = sh_pt.x;
  assign ax_len[0] = sh_sz.width;
  assign ax_lim[0] = H_LIM;
  assign ax_pos[1] = sh_pt.y;
  assign ax_len[1] = sh_sz.height;
  assign ax_lim[1] = V_LIM;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      vga_geom_clamp u_clamp (
        .pos         (ax_pos[gi]),
        .len         (ax_len[gi]),
        .limit       (ax_lim[gi]),
        .len_clamped (ax_out[gi])
      );
    end
  endgenerate

  assign clamped_sz.width  = ax_out[0];
  assign clamped_sz.height = ax_out[1];

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // A stopped driver has no frame boundary coming, so commit at once.
        // A sync edge in the same cycle as the write is deliberately not
        // used: the commit waits for the following edge.
        if (commit_wr) state_next = (ctrl_reg == '0) ? ST_COMMIT : ST_PENDING;
      end
      ST_PENDING: begin
        if (sync_edge) state_next = ST_COMMIT;
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- status
  // Set events override a simultaneous write-one-to-clear.
  assign status_set  = {state_reg == ST_COMMIT, sync_edge};
  assign status_w1c  = (wr_en && addr == REG_STATUS) ? wdata[1:0] : 2'b00;
  assign status_next = (status_reg & ~status_w1c) | status_set;

  // ------------------------------------------------------------ read mux
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_SH_CTRL:   rd_mux = sh_ctrl_reg;
      REG_SH_POINT:  rd_mux = sh_point_reg;
      REG_SH_SIZE:   rd_mux = sh_size_reg;
      REG_COMMIT:    rd_mux = {31'd0, state_reg != ST_IDLE};
      REG_STATUS:    rd_mux = {30'd0, status_reg};
      REG_IRQ_EN:    rd_mux = {30'd0, irq_en_reg};
      REG_FRAME_CNT: rd_mux = frame_cnt_reg;
      REG_ACT_SIZE:  rd_mux = size_reg;
      default:       rd_mux = '0;
    endcase
  end

  // ------------------------------------------------------ registers / bus
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_ctrl_reg      <= '0;
      sh_point_reg     <= '0;
      sh_size_reg      <= '0;
      ctrl_reg         <= '0;
      point_reg        <= '0;
      size_reg         <= '0;
      status_reg       <= '0;
      irq_en_reg       <= '0;
      frame_cnt_reg    <= '0;
      frame_sync_d_reg <= 1'b0;
      ack_reg          <= 1'b0;
      rdata_reg        <= '0;
      irq_reg          <= 1'b0;
    end else begin
      frame_sync_d_reg <= frame_sync;
      ack_reg          <= req;
      // Sampled before this cycle's write lands, so reads see the old value.
      rdata_reg        <= rd_en ? rd_mux : '0;
      status_reg       <= status_next;
      irq_reg          <= |(status_reg & irq_en_reg);

      if (wr_en) begin
        case (addr)
          REG_SH_CTRL:  sh_ctrl_reg  <= merge_bytes(sh_ctrl_reg,  wdata, wstrb);
          REG_SH_POINT: sh_point_reg <= merge_bytes(sh_point_reg, wdata, wstrb);
          REG_SH_SIZE:  sh_size_reg  <= merge_bytes(sh_size_reg,  wdata, wstrb);
          REG_IRQ_EN:   irq_en_reg   <= wdata[1:0];
          default: ;
        endcase
      end

      if (state_reg == ST_COMMIT) begin
        ctrl_reg  <= sh_ctrl_reg;
        point_reg <= sh_point_reg;
        size_reg  <= clamped_sz;
      end

      // Frames are only counted while the driver is running.
      if (sync_edge && ctrl_reg != '0) begin
        frame_cnt_reg <= frame_cnt_reg + 32'd1;
      end
    end
  end

  assign ack       = ack_reg;
  assign rdata     = rdata_reg;
  assign ctrl      = ctrl_reg;
  assign img_point = point_reg;
  assign img_size  = size_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_vga_cfg_sched.sv
module tb_vga_cfg_sched;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        frame_sync = 1'b0;
  logic [31:0] ctrl, img_point, img_size;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic        req_q = 1'b0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] act_ctrl_exp = '0;
  logic [31:0] last_size_exp = '0;

  vga_cfg_sched dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ack(ack), .rdata(rdata), .frame_sync(frame_sync),
    .ctrl(ctrl), .img_point(img_point), .img_size(img_size), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_q <= req;

  // Scoreboard: every transaction's expected rdata was queued when issued.
  always @(negedge clk) begin
    checks++;
    if (ack !== req_q) begin
      errors++;
      $display("FAIL ack_timing: ack=%b required=%b at %0t", ack, req_q, $time);
    end
    if (ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: ack with rdata=%h but nothing expected", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h required %h at %0t", rdata, e, $time);
        end else begin
          $display("txn ack rdata=%h at %0t", rdata, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Bus access helpers: start and end just after a falling edge.
  task automatic bus_op(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd);
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    exp_q.push_back(w ? 32'd0 : exp_rd);
    @(negedge clk);
    req = 1'b0; we = 1'b0; wstrb = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_op(1'b1, a, d, 4'hF, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    bus_op(1'b0, a, 32'd0, 4'h0, e);
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    if (act_ctrl_exp != 0) exp_cnt++;
  endtask

  function automatic logic [31:0] clamp_ref(input logic [31:0] p, input logic [31:0] s);
    int x, y, w, h, cw, ch;
    x = int'(p[31:16]); y = int'(p[15:0]);
    w = int'(s[15:0]);  h = int'(s[31:16]);
    cw = (x >= 640) ? 0 : ((x + w > 640) ? 640 - x : w);
    ch = (y >= 480) ? 0 : ((y + h > 480) ? 480 - y : h);
    return {ch[15:0], cw[15:0]};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl, img_point, img_size, irq, ack, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ctrl=%h point=%h size=%h irq=%b ack=%b rdata=%h required all 0",
               ctrl, img_point, img_size, irq, ack, rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd(3'(i), 32'd0);
    @(negedge clk);
  endtask

  task automatic test_bus();
    wr(REG_SH_POINT, 32'h1122_3344);
    bus_op(1'b1, REG_SH_POINT, 32'hAABB_CCDD, 4'b0101, 32'd0);
    rd(REG_SH_POINT, 32'h11BB_33DD);
    wr(REG_FRAME_CNT, 32'd123);
    wr(REG_ACT_SIZE, 32'h55AA_55AA);
    rd(REG_FRAME_CNT, 32'd0);
    rd(REG_ACT_SIZE, 32'd0);
    checks++;
    if (img_size !== 32'd0) begin
      errors++;
      $display("FAIL ro_write: img_size=%h required 0", img_size);
    end
  endtask

  task automatic test_stopped_commit();
    wr(REG_SH_CTRL, 32'd1);
    wr(REG_SH_POINT, {16'd10, 16'd20});
    wr(REG_SH_SIZE, {16'd50, 16'd100});
    wr(REG_COMMIT, 32'd1);
    checks++;
    if (ctrl !== 32'd0) begin
      errors++;
      $display("FAIL stopped_early: ctrl=%h required 0 one cycle after commit", ctrl);
    end
    @(negedge clk);
    checks++;
    if (ctrl !== 32'd1 || img_point !== {16'd10, 16'd20} || img_size !== {16'd50, 16'd100}) begin
      errors++;
      $display("FAIL stopped_commit: ctrl=%h point=%h size=%h required 1/000a0014/00320064",
               ctrl, img_point, img_size);
    end
    act_ctrl_exp = 32'd1;
    last_size_exp = {16'd50, 16'd100};
    rd(REG_STATUS, 32'd2);
    rd(REG_COMMIT, 32'd0);
    wr(REG_STATUS, 32'd3);
    rd(REG_STATUS, 32'd0);
  endtask

  task automatic test_deferred_commit();
    wr(REG_SH_SIZE, {16'd60, 16'd200});
    wr(REG_COMMIT, 32'd1);
    rd(REG_COMMIT, 32'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (img_size !== last_size_exp) begin
      errors++;
      $display("FAIL deferred_hold: size=%h required %h", img_size, last_size_exp);
    end
    pulse_sync();
    checks++;
    if (img_size !== last_size_exp) begin
      errors++;
      $display("FAIL deferred_early: size=%h required %h", img_size, last_size_exp);
    end
    @(negedge clk);
    checks++;
    if (img_size !== {16'd60, 16'd200}) begin
      errors++;
      $display("FAIL deferred_commit: size=%h required %h", img_size, {16'd60, 16'd200});
    end
    last_size_exp = {16'd60, 16'd200};
    rd(REG_FRAME_CNT, exp_cnt);
    rd(REG_STATUS, 32'd3);
    wr(REG_STATUS, 32'd3);
  endtask

  task automatic test_clamp();
    logic [31:0] pts [5];
    logic [31:0] szs [5];
    logic [31:0] e;
    pts = '{{16'd600, 16'd10}, {16'd0, 16'd500}, {16'd540, 16'd470},
            {16'd100, 16'd0}, {16'd640, 16'd479}};
    szs = '{{16'd20, 16'd100}, {16'd30, 16'd64}, {16'd10, 16'd100},
            {16'hFFFF, 16'hFFFF}, {16'd2, 16'd5}};
    for (int i = 0; i < 5; i++) begin
      wr(REG_SH_POINT, pts[i]);
      wr(REG_SH_SIZE, szs[i]);
      wr(REG_COMMIT, 32'd1);
      pulse_sync();
      @(negedge clk);
      e = clamp_ref(pts[i], szs[i]);
      checks++;
      if (img_size !== e || img_point !== pts[i]) begin
        errors++;
        $display("FAIL clamp_%0d: size=%h point=%h required %h %h", i, img_size, img_point, e, pts[i]);
      end
      rd(REG_ACT_SIZE, e);
      last_size_exp = e;
    end
    wr(REG_STATUS, 32'd3);
  endtask

  task automatic test_simultaneous();
    wr(REG_SH_POINT, 32'd0);
    wr(REG_SH_SIZE, {16'd7, 16'd9});
    frame_sync = 1'b1;
    wr(REG_COMMIT, 32'd1);
    frame_sync = 1'b0;
    exp_cnt++;
    repeat (2) @(negedge clk);
    checks++;
    if (img_size !== last_size_exp) begin
      errors++;
      $display("FAIL sim_commit_early: size=%h required %h", img_size, last_size_exp);
    end
    rd(REG_COMMIT, 32'd1);
    pulse_sync();
    @(negedge clk);
    checks++;
    if (img_size !== {16'd7, 16'd9}) begin
      errors++;
      $display("FAIL sim_commit: size=%h required %h", img_size, {16'd7, 16'd9});
    end
    last_size_exp = {16'd7, 16'd9};
    wr(REG_STATUS, 32'd3);
    rd(REG_STATUS, 32'd0);
    frame_sync = 1'b1;
    wr(REG_STATUS, 32'd1);
    frame_sync = 1'b0;
    exp_cnt++;
    rd(REG_STATUS, 32'd1);
    wr(REG_STATUS, 32'd1);
  endtask

  task automatic test_irq();
    wr(REG_STATUS, 32'd3);
    wr(REG_IRQ_EN, 32'd1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: irq=%b required 0", irq);
    end
    pulse_sync();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b required 1", irq);
    end
    wr(REG_STATUS, 32'd1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: irq=%b required 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b required 0", irq);
    end
    rd(REG_IRQ_EN, 32'd1);
    wr(REG_IRQ_EN, 32'd0);
  endtask

  task automatic test_frame_cnt();
    rd(REG_FRAME_CNT, exp_cnt);
    force dut.frame_cnt_reg = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.frame_cnt_reg;
    exp_cnt = 32'hFFFF_FFFE;
    rd(REG_FRAME_CNT, exp_cnt);
    pulse_sync();
    rd(REG_FRAME_CNT, exp_cnt);
    pulse_sync();
    rd(REG_FRAME_CNT, exp_cnt);
    wr(REG_STATUS, 32'd3);
  endtask

  task automatic test_reset_pending();
    wr(REG_SH_SIZE, {16'd3, 16'd4});
    wr(REG_COMMIT, 32'd1);
    rd(REG_COMMIT, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    act_ctrl_exp = '0;
    exp_cnt = '0;
    checks++;
    if ({ctrl, img_point, img_size, irq} !== '0) begin
      errors++;
      $display("FAIL reset_pending: ctrl=%h point=%h size=%h irq=%b required all 0",
               ctrl, img_point, img_size, irq);
    end
    rd(REG_COMMIT, 32'd0);
    pulse_sync();
    repeat (3) @(negedge clk);
    checks++;
    if (img_size !== 32'd0 || ctrl !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_commit: size=%h ctrl=%h required 0", img_size, ctrl);
    end
    rd(REG_FRAME_CNT, exp_cnt);
  endtask

  initial begin
    test_reset();
    test_bus();
    test_stopped_commit();
    test_deferred_commit();
    test_clamp();
    test_simultaneous();
    test_irq();
    test_frame_cnt();
    test_reset_pending();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d transactions never acknowledged, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
